io_responder: RTL and testbench

// - Memory-mapped peripheral responder on the processor bus: memread/memwrite/adr/writedata in, read data out.
// - Claims the top 16 bytes of address space (adr[7:4]==4'hF); the RAM answers all other addresses.
// - Top level muxes memdata = io_hit ? io_rdata : ram data.
// - Provides GPIO out/in, a prescaled 8-bit timer with compare match, and a level interrupt.

---
 rtl/io_responder_pkg.sv | 24 ++
 rtl/io_responder_if.sv | 25 ++
 rtl/io_timer.sv | 74 +++++++
 rtl/io_responder.sv | 115 +++++++++++
 tb/tb_io_responder.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_responder_pkg.sv
// Shared constants for the memory-mapped IO responder: IO window base, register offsets
// within the window, and bit positions inside CTRL and STAT.
package mips_io_pkg;

   localparam logic [3:0] IO_BASE = 4'hF;

   // Register offsets (adr[3:0])
   localparam logic [3:0] GPO  = 4'h0;
   localparam logic [3:0] GPI  = 4'h1;
   localparam logic [3:0] CNT  = 4'h2;
   localparam logic [3:0] CMP  = 4'h3;
   localparam logic [3:0] CTRL = 4'h4;
   localparam logic [3:0] STAT = 4'h5;
   localparam logic [3:0] PRE  = 4'h6;

   // CTRL bits
   localparam int unsigned CTRL_EN    = 0;
   localparam int unsigned CTRL_IRQEN = 1;
   localparam int unsigned CTRL_AUTO  = 2;

   // STAT bits
   localparam int unsigned STAT_MATCH = 0;

endpackage

// File: rtl/io_responder_if.sv
// Processor bus as seen by the IO responder.
//   memread/memwrite : bus strobes (master -> slave)
//   adr/writedata    : byte address and write data (master -> slave)
//   io_hit           : combinational window hit (slave -> master)
//   io_rdata         : registered read data (slave -> master)
interface io_responder_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             memread;
   logic             memwrite;
   logic [WIDTH-1:0] adr;
   logic [WIDTH-1:0] writedata;
   logic             io_hit;
   logic [WIDTH-1:0] io_rdata;

   modport master (
      output memread, memwrite, adr, writedata,
      input  io_hit, io_rdata
   );

   modport slave (
      input  memread, memwrite, adr, writedata,
      output io_hit, io_rdata
   );
endinterface

// File: rtl/io_timer.sv
// Prescaled timer: prescaler psc, counter CNT, compare CMP, prescale PRE.
//   clk, reset         : clock, async active-low reset
//   enable_i, auto_i   : CTRL.enable and CTRL.auto_reload
//   cnt/cmp/pre_we_i   : CPU write strobes, data on wdata_i
//   cnt_o/cmp_o/pre_o  : register values for readback
//   match_set_o        : tick with CNT==CMP this cycle (sets STAT.match)
module io_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable_i,
   input  logic             auto_i,
   input  logic             cnt_we_i,
   input  logic             cmp_we_i,
   input  logic             pre_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic [WIDTH-1:0] cmp_o,
   output logic [WIDTH-1:0] pre_o,
   output logic             match_set_o
);

   logic [WIDTH-1:0] psc_q, psc_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] cmp_q, cmp_d;
   logic [WIDTH-1:0] pre_q, pre_d;
   logic             tick;

   always_comb begin
      tick        = enable_i && (psc_q == pre_q);
      match_set_o = tick && (cnt_q == cmp_q);

      // Dropping enable also returns the prescaler to 0.
      psc_d = psc_q;
      if (!enable_i || tick) begin
         psc_d = '0;
      end else begin
         psc_d = psc_q + WIDTH'(1);
      end

      // CPU write beats the timer update in the same cycle.
      cnt_d = cnt_q;
      if (cnt_we_i) begin
         cnt_d = wdata_i;
      end else if (match_set_o && auto_i) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + WIDTH'(1);
      end

      cmp_d = cmp_we_i ? wdata_i : cmp_q;
      pre_d = pre_we_i ? wdata_i : pre_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         psc_q <= '0;
         cnt_q <= '0;
         cmp_q <= '0;
         pre_q <= '0;
      end else begin
         psc_q <= psc_d;
         cnt_q <= cnt_d;
         cmp_q <= cmp_d;
         pre_q <= pre_d;
      end
   end

   assign cnt_o = cnt_q;
   assign cmp_o = cmp_q;
   assign pre_o = pre_q;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped IO responder occupying the top 16 bytes of the address space.
//   clk, reset : clock, async active-low reset
//   bus        : processor bus slave (strobes, address, write data, io_hit, io_rdata)
//   gpio_in    : external inputs, asynchronous to clk
//   gpio_out   : GPO register
//   irq        : registered STAT.match & CTRL.irq_en
module io_responder
   import mips_io_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter logic [3:0]  IO_BASE = mips_io_pkg::IO_BASE
) (
   input  logic             clk,
   input  logic             reset,
   io_responder_if.slave    bus,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic             irq
);

   logic [3:0]       off;
   logic             hit, wr_en, rd_en;
   logic [WIDTH-1:0] gpo_q, gpo_d;
   logic [WIDTH-1:0] gpi_meta_q, gpi_q;
   logic [2:0]       ctrl_q, ctrl_d;
   logic             match_q, match_d;
   logic             irq_q, irq_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] rdata_mux;
   logic [WIDTH-1:0] cnt, cmp, pre;
   logic             match_set;

   always_comb begin
      off   = bus.adr[3:0];
      hit   = (bus.adr[WIDTH-1 -: 4] == IO_BASE) && (bus.memread || bus.memwrite);
      wr_en = hit && bus.memwrite;
      // A simultaneous write suppresses the read.
      rd_en = hit && bus.memread && !bus.memwrite;
   end

   io_timer #(
      .WIDTH (WIDTH)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .enable_i    (ctrl_q[CTRL_EN]),
      .auto_i      (ctrl_q[CTRL_AUTO]),
      .cnt_we_i    (wr_en && (off == CNT)),
      .cmp_we_i    (wr_en && (off == CMP)),
      .pre_we_i    (wr_en && (off == PRE)),
      .wdata_i     (bus.writedata),
      .cnt_o       (cnt),
      .cmp_o       (cmp),
      .pre_o       (pre),
      .match_set_o (match_set)
   );

   always_comb begin
      gpo_d   = gpo_q;
      ctrl_d  = ctrl_q;
      match_d = match_q;
      rdata_d = rdata_q;

      if (wr_en && (off == GPO))  gpo_d  = bus.writedata;
      if (wr_en && (off == CTRL)) ctrl_d = bus.writedata[2:0];

      // A match set in the same cycle as a W1C keeps the flag.
      if (match_set) begin
         match_d = 1'b1;
      end else if (wr_en && (off == STAT) && bus.writedata[STAT_MATCH]) begin
         match_d = 1'b0;
      end

      irq_d = match_q && ctrl_q[CTRL_IRQEN];

      case (off)
         GPO:     rdata_mux = gpo_q;
         GPI:     rdata_mux = gpi_q;
         CNT:     rdata_mux = cnt;
         CMP:     rdata_mux = cmp;
         CTRL:    rdata_mux = {{(WIDTH-3){1'b0}}, ctrl_q};
         STAT:    rdata_mux = {{(WIDTH-1){1'b0}}, match_q};
         PRE:     rdata_mux = pre;
         default: rdata_mux = '0;
      endcase

      if (rd_en) rdata_d = rdata_mux;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gpo_q      <= '0;
         gpi_meta_q <= '0;
         gpi_q      <= '0;
         ctrl_q     <= '0;
         match_q    <= 1'b0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         gpo_q      <= gpo_d;
         gpi_meta_q <= gpio_in;
         gpi_q      <= gpi_meta_q;
         ctrl_q     <= ctrl_d;
         match_q    <= match_d;
         irq_q      <= irq_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.io_hit   = hit;
   assign bus.io_rdata = rdata_q;
   assign gpio_out     = gpo_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder. Expected read data is queued when a read is
// issued and popped when io_rdata is sampled, 1 ns after the rising edge.
module tb_io_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out;
   logic       irq;

   io_responder_if #(.WIDTH(8)) bus ();

   io_responder #(
      .WIDTH   (8),
      .IO_BASE (4'hF)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp;
   logic [7:0] got;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.memread   = 1'b0;
      bus.memwrite  = 1'b0;
      bus.adr       = 8'h00;
      bus.writedata = 8'h00;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus.memread   = 1'b0;
      bus.memwrite  = 1'b1;
      bus.adr       = a;
      bus.writedata = d;
      step();
      idle();
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      bus.memread  = 1'b1;
      bus.memwrite = 1'b0;
      bus.adr      = a;
      step();
      d = bus.io_rdata;
      idle();
   endtask

   task automatic test_reset();
      logic [7:0] regs[5];
      regs = '{8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6};
      reset   = 1'b0;
      gpio_in = 8'h00;
      idle();
      repeat (2) step();
      reset = 1'b1;
      checks++; if (gpio_out !== 8'h00) begin errors++;
         $display("FAIL por_gpio_out: got %h want 00", gpio_out); end
      checks++; if (irq !== 1'b0) begin errors++;
         $display("FAIL por_irq: got %b want 0", irq); end
      checks++; if (bus.io_rdata !== 8'h00) begin errors++;
         $display("FAIL por_io_rdata: got %h want 00", bus.io_rdata); end

      // Build up state: GPO, a pending match and irq, then a nonzero io_rdata.
      wr(8'hF0, 8'h77);
      wr(8'hF4, 8'h03);
      step();
      step();
      checks++; if (irq !== 1'b1) begin errors++;
         $display("FAIL pre_reset_irq: got %b want 1", irq); end
      exp_q.push_back(8'h77);
      rd(8'hF0, got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++;
         $display("FAIL pre_reset_rd_gpo: got %h want %h", got, exp); end

      // Assert reset between edges with a read in flight.
      bus.memread = 1'b1;
      bus.adr     = 8'hF2;
      #3 reset = 1'b0;
      #1;
      checks++; if (gpio_out !== 8'h00) begin errors++;
         $display("FAIL async_rst_gpio_out: got %h want 00", gpio_out); end
      checks++; if (irq !== 1'b0) begin errors++;
         $display("FAIL async_rst_irq: got %b want 0", irq); end
      checks++; if (bus.io_rdata !== 8'h00) begin errors++;
         $display("FAIL async_rst_io_rdata: got %h want 00", bus.io_rdata); end
      step();
      step();
      idle();
      reset = 1'b1;

      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(8'h00);
         rd(regs[i], got);
         exp = exp_q.pop_front();
         checks++; if (got !== exp) begin errors++;
            $display("FAIL rst_reg_%h: got %h want %h", regs[i], got, exp); end
      end
   endtask

   task automatic test_gpio();
      logic [7:0] gpi_exp[4];
      gpi_exp = '{8'h00, 8'h00, 8'h3C, 8'h3C};
      wr(8'hF0, 8'hA5);
      checks++; if (gpio_out !== 8'hA5) begin errors++;
         $display("FAIL gpo_out: got %h want a5", gpio_out); end
      exp_q.push_back(8'hA5);
      rd(8'hF0, got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++;
         $display("FAIL gpo_read: got %h want %h", got, exp); end

      // Two sync flops plus the read register: visible from the 3rd edge.
      gpio_in     = 8'h3C;
      bus.memread = 1'b1;
      bus.adr     = 8'hF1;
      for (int i = 0; i < 4; i++) exp_q.push_back(gpi_exp[i]);
      for (int i = 0; i < 4; i++) begin
         step();
         exp = exp_q.pop_front();
         checks++; if (bus.io_rdata !== exp) begin errors++;
            $display("FAIL gpi_edge%0d: got %h want %h", i + 1, bus.io_rdata, exp); end
      end
      idle();
   endtask

   task automatic test_timer_basic();
      logic [7:0] cnt_exp[5];
      cnt_exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
      wr(8'hF6, 8'h00);
      wr(8'hF3, 8'h03);
      wr(8'hF4, 8'h07);
      bus.memread = 1'b1;
      bus.adr     = 8'hF2;
      for (int i = 0; i < 5; i++) exp_q.push_back(cnt_exp[i]);
      for (int i = 0; i < 5; i++) begin
         step();
         exp = exp_q.pop_front();
         checks++; if (bus.io_rdata !== exp) begin errors++;
            $display("FAIL timer_cnt%0d: got %h want %h", i, bus.io_rdata, exp); end
         if (i == 3) begin
            checks++; if (irq !== 1'b0) begin errors++;
               $display("FAIL timer_irq_early: got %b want 0", irq); end
         end
         if (i == 4) begin
            checks++; if (irq !== 1'b1) begin errors++;
               $display("FAIL timer_irq_rise: got %b want 1", irq); end
         end
      end
      bus.adr = 8'hF5;
      exp_q.push_back(8'h01);
      step();
      exp = exp_q.pop_front();
      checks++; if (bus.io_rdata !== exp) begin errors++;
         $display("FAIL timer_stat: got %h want %h", bus.io_rdata, exp); end
      idle();
      wr(8'hF4, 8'h00);
      wr(8'hF5, 8'h01);
      step();
      checks++; if (irq !== 1'b0) begin errors++;
         $display("FAIL timer_irq_fall: got %b want 0", irq); end
      exp_q.push_back(8'h00);
      rd(8'hF5, got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++;
         $display("FAIL timer_stat_clr: got %h want %h", got, exp); end
   endtask

   task automatic test_w1c_vs_set();
      wr(8'hF6, 8'h00);
      wr(8'hF2, 8'h05);
      wr(8'hF3, 8'h05);
      wr(8'hF5, 8'h01);
      wr(8'hF4, 8'h01);
      wr(8'hF5, 8'h01);  // same edge as the matching tick
      wr(8'hF4, 8'h00);
      exp_q.push_back(8'h01);
      rd(8'hF5, got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++;
         $display("FAIL w1c_vs_set: got %h want %h", got, exp); end
      wr(8'hF5, 8'h01);
      exp_q.push_back(8'h00);
      rd(8'hF5, got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++;
         $display("FAIL w1c_plain: got %h want %h", got, exp); end
   endtask

   task automatic test_prescale_wrap();
      logic [7:0] seq[10];
      seq = '{8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01};
      wr(8'hF6, 8'h02);
      wr(8'hF3, 8'h10);
      wr(8'hF2, 8'hFE);
      wr(8'hF5, 8'h01);
      wr(8'hF4, 8'h01);
      bus.memread = 1'b1;
      bus.adr     = 8'hF2;
      for (int i = 0; i < 10; i++) exp_q.push_back(seq[i]);
      for (int i = 0; i < 10; i++) begin
         step();
         exp = exp_q.pop_front();
         checks++; if (bus.io_rdata !== exp) begin errors++;
            $display("FAIL psc_cnt%0d: got %h want %h", i, bus.io_rdata, exp); end
      end
      bus.adr = 8'hF5;
      exp_q.push_back(8'h00);
      step();
      exp = exp_q.pop_front();
      checks++; if (bus.io_rdata !== exp) begin errors++;
         $display("FAIL psc_no_match: got %h want %h", bus.io_rdata, exp); end
      idle();
      wr(8'hF4, 8'h00);
   endtask

   task automatic test_cnt_priority();
      wr(8'hF6, 8'h00);
      wr(8'hF3, 8'h80);
      wr(8'hF2, 8'h10);
      wr(8'hF4, 8'h01);
      step();
      step();
      wr(8'hF2, 8'h40);  // lands on a tick edge
      exp_q.push_back(8'h40);
      rd(8'hF2, got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++;
         $display("FAIL cnt_write_priority: got %h want %h", got, exp); end
      wr(8'hF4, 8'h00);
   endtask

   task automatic test_decode();
      exp_q.push_back(8'h00);
      rd(8'hF9, got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++;
         $display("FAIL rd_f9: got %h want %h", got, exp); end
      wr(8'hF9, 8'hFF);
      checks++; if (gpio_out !== 8'hA5) begin errors++;
         $display("FAIL wr_f9_gpo: got %h want a5", gpio_out); end
      exp_q.push_back(8'h00);
      rd(8'hF4, got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++;
         $display("FAIL wr_f9_ctrl: got %h want %h", got, exp); end
      exp_q.push_back(8'h00);
      rd(8'hF6, got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++;
         $display("FAIL wr_f9_pre: got %h want %h", got, exp); end
      exp_q.push_back(8'hA5);
      rd(8'hF0, got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++;
         $display("FAIL wr_f9_gpo_rd: got %h want %h", got, exp); end

      bus.memread = 1'b1;
      bus.adr     = 8'h7F;
      #1;
      checks++; if (bus.io_hit !== 1'b0) begin errors++;
         $display("FAIL hit_7f: got %b want 0", bus.io_hit); end
      step();
      checks++; if (bus.io_rdata !== 8'hA5) begin errors++;
         $display("FAIL rdata_hold_7f: got %h want a5", bus.io_rdata); end
      bus.adr = 8'hF0;
      #1;
      checks++; if (bus.io_hit !== 1'b1) begin errors++;
         $display("FAIL hit_f0: got %b want 1", bus.io_hit); end

      // Read and write together: write happens, read data holds.
      bus.memwrite  = 1'b1;
      bus.writedata = 8'h5A;
      step();
      idle();
      checks++; if (gpio_out !== 8'h5A) begin errors++;
         $display("FAIL rw_both_gpo: got %h want 5a", gpio_out); end
      checks++; if (bus.io_rdata !== 8'hA5) begin errors++;
         $display("FAIL rw_both_rdata: got %h want a5", bus.io_rdata); end
   endtask

   initial begin
      test_reset();
      test_gpio();
      test_timer_basic();
      test_w1c_vs_set();
      test_prescale_wrap();
      test_cnt_priority();
      test_decode();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
